// File: rtl/game_ctrl_fsm.sv
// Game-flow controller for the puzzle board: board select / play / win / loss / pause, with move counting.
// Optional best-score record tracking is enabled by defining GAME_BEST_RECORD_EN.
module game_ctrl_fsm #(
  parameter int STEP_W     = 8,
  parameter int STEP_LIMIT = 0,
  parameter bit SAT_MODE   = 1'b0
) (
  input  logic              clk_d,
  input  logic              rst,
  input  logic              start_sw,
  input  logic              pause_sw,
  input  logic              win_flag,
  input  logic              active,
  output logic [2:0]        game_status,
  output logic [STEP_W-1:0] step_number,
  output logic [STEP_W-1:0] best_steps,
  output logic              best_valid,
  output logic              new_record
);

  typedef enum logic [2:0] {
    CHOSE_BOARD  = 3'd0,
    GAME_INITIAL = 3'd1,
    GAMING       = 3'd2,
    WINNED       = 3'd3,
    LOST         = 3'd4,
    PAUSED       = 3'd5
  } state_t;

  localparam logic [STEP_W-1:0] STEP_MAX = '1;
  localparam logic [STEP_W-1:0] LIMIT_V  = STEP_W'(STEP_LIMIT);

  state_t            state;
  logic [STEP_W-1:0] step_q;

  function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] s);
    if (s == STEP_MAX)
      return SAT_MODE ? STEP_MAX : '0;
    return s + STEP_W'(1);
  endfunction

  function automatic logic hits_limit(input logic [STEP_W-1:0] s);
    return (STEP_LIMIT != 0) && (s == LIMIT_V);
  endfunction

`ifdef GAME_BEST_RECORD_EN
  logic [STEP_W-1:0] best_q;
  logic              best_vld_q;
  logic              nr_q;
`endif

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state  <= CHOSE_BOARD;
      step_q <= '0;
`ifdef GAME_BEST_RECORD_EN
      best_q     <= '0;
      best_vld_q <= 1'b0;
      nr_q       <= 1'b0;
`endif
    end else begin
`ifdef GAME_BEST_RECORD_EN
      nr_q <= 1'b0;
`endif
      // Dropping start_sw overrides every state; the record is deliberately kept.
      if (!start_sw) begin
        state  <= CHOSE_BOARD;
        step_q <= '0;
      end else begin
        case (state)
          CHOSE_BOARD: begin
            step_q <= '0;
            state  <= GAME_INITIAL;
          end
          GAME_INITIAL, GAMING: begin
            if (win_flag) begin
              state <= WINNED;
`ifdef GAME_BEST_RECORD_EN
              if (!best_vld_q || (step_q < best_q)) begin
                best_q     <= step_q;
                best_vld_q <= 1'b1;
                nr_q       <= 1'b1;
              end
`endif
            end else if (pause_sw) begin
              state <= PAUSED;
            end else if (active) begin
              step_q <= step_inc(step_q);
              state  <= hits_limit(step_inc(step_q)) ? LOST : GAMING;
            end
          end
          PAUSED: begin
            if (!pause_sw)
              state <= (step_q == '0) ? GAME_INITIAL : GAMING;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign game_status = state;
  assign step_number = step_q;

`ifdef GAME_BEST_RECORD_EN
  assign best_steps = best_q;
  assign best_valid = best_vld_q;
  assign new_record = nr_q;
`else
  assign best_steps = '0;
  assign best_valid = 1'b0;
  assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed self-checking bench for game_ctrl_fsm; four instances share stimulus to cover
// default, 4-bit wrap, 4-bit saturate and move-limit configurations.
module tb_game_ctrl_fsm;

`ifdef GAME_BEST_RECORD_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic clk_d, rst, start_sw, pause_sw, win_flag, active;

  logic [2:0] gs_m, gs_w, gs_s, gs_l;
  logic [7:0] sn_m, bs_m, sn_l, bs_l;
  logic [3:0] sn_w, bs_w, sn_s, bs_s;
  logic       bv_m, nr_m, bv_w, nr_w, bv_s, nr_s, bv_l, nr_l;

  int errors = 0;
  int checks = 0;

  game_ctrl_fsm u_main (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .pause_sw(pause_sw), .win_flag(win_flag),
    .active(active), .game_status(gs_m), .step_number(sn_m), .best_steps(bs_m),
    .best_valid(bv_m), .new_record(nr_m));

  game_ctrl_fsm #(.STEP_W(4), .STEP_LIMIT(0), .SAT_MODE(1'b0)) u_wrap (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .pause_sw(pause_sw), .win_flag(win_flag),
    .active(active), .game_status(gs_w), .step_number(sn_w), .best_steps(bs_w),
    .best_valid(bv_w), .new_record(nr_w));

  game_ctrl_fsm #(.STEP_W(4), .STEP_LIMIT(0), .SAT_MODE(1'b1)) u_sat (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .pause_sw(pause_sw), .win_flag(win_flag),
    .active(active), .game_status(gs_s), .step_number(sn_s), .best_steps(bs_s),
    .best_valid(bv_s), .new_record(nr_s));

  game_ctrl_fsm #(.STEP_W(8), .STEP_LIMIT(5), .SAT_MODE(1'b0)) u_lim (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .pause_sw(pause_sw), .win_flag(win_flag),
    .active(active), .game_status(gs_l), .step_number(sn_l), .best_steps(bs_l),
    .best_valid(bv_l), .new_record(nr_l));

  initial clk_d = 1'b0;
  always #5 clk_d = ~clk_d;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_sw = 1'b0; pause_sw = 1'b0; win_flag = 1'b0; active = 1'b0;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_sw = 1'b0; pause_sw = 1'b0; win_flag = 1'b0; active = 1'b0;
    #2;
    if (gs_m !== 3'd0) begin errors++; $display("FAIL rst_status: got %0d want 0", gs_m); end checks++;
    if (sn_m !== 8'd0) begin errors++; $display("FAIL rst_step: got %0d want 0", sn_m); end checks++;
    if (bs_m !== 8'd0) begin errors++; $display("FAIL rst_best: got %0d want 0", bs_m); end checks++;
    if (bv_m !== 1'b0) begin errors++; $display("FAIL rst_best_valid: got %0b want 0", bv_m); end checks++;
    if (nr_m !== 1'b0) begin errors++; $display("FAIL rst_new_record: got %0b want 0", nr_m); end checks++;
    start_sw = 1'b1; active = 1'b1;
    tick(2);
    if (gs_m !== 3'd0 || sn_m !== 8'd0) begin
      errors++; $display("FAIL rst_held: got status %0d step %0d want 0 0", gs_m, sn_m);
    end checks++;
    active = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    start_sw = 1'b1;
    tick();
    if (gs_m !== 3'd1 || sn_m !== 8'd0) begin
      errors++; $display("FAIL t1_init: got status %0d step %0d want 1 0", gs_m, sn_m);
    end checks++;
    active = 1'b1;
    tick();
    if (gs_m !== 3'd2 || sn_m !== 8'd1) begin
      errors++; $display("FAIL t1_first_move: got status %0d step %0d want 2 1", gs_m, sn_m);
    end checks++;
    tick(2);
    active = 1'b0;
    if (gs_m !== 3'd2 || sn_m !== 8'd3) begin
      errors++; $display("FAIL t1_three_moves: got status %0d step %0d want 2 3", gs_m, sn_m);
    end checks++;
    tick();
    if (sn_m !== 8'd3) begin errors++; $display("FAIL t1_idle_hold: got %0d want 3", sn_m); end checks++;
  endtask

  task automatic test_overflow();
    do_reset();
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(15);
    if (sn_w !== 4'd15 || gs_w !== 3'd2) begin
      errors++; $display("FAIL t2_wrap_max: got step %0d status %0d want 15 2", sn_w, gs_w);
    end checks++;
    if (sn_s !== 4'd15) begin errors++; $display("FAIL t2_sat_max: got %0d want 15", sn_s); end checks++;
    if (gs_l !== 3'd4 || sn_l !== 8'd5) begin
      errors++; $display("FAIL t2_limit_side: got status %0d step %0d want 4 5", gs_l, sn_l);
    end checks++;
    tick();
    if (sn_w !== 4'd0 || gs_w !== 3'd2) begin
      errors++; $display("FAIL t2_wrap_zero: got step %0d status %0d want 0 2", sn_w, gs_w);
    end checks++;
    if (sn_s !== 4'd15 || gs_s !== 3'd2) begin
      errors++; $display("FAIL t2_sat_hold: got step %0d status %0d want 15 2", sn_s, gs_s);
    end checks++;
    if (sn_m !== 8'd16) begin errors++; $display("FAIL t2_wide_count: got %0d want 16", sn_m); end checks++;
    tick();
    active = 1'b0;
    if (sn_w !== 4'd1 || sn_s !== 4'd15) begin
      errors++; $display("FAIL t2_after_wrap: got wrap %0d sat %0d want 1 15", sn_w, sn_s);
    end checks++;
  endtask

  task automatic test_limit();
    do_reset();
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(4);
    if (gs_l !== 3'd2 || sn_l !== 8'd4) begin
      errors++; $display("FAIL t3_below_limit: got status %0d step %0d want 2 4", gs_l, sn_l);
    end checks++;
    tick();
    if (gs_l !== 3'd4 || sn_l !== 8'd5) begin
      errors++; $display("FAIL t3_at_limit: got status %0d step %0d want 4 5", gs_l, sn_l);
    end checks++;
    tick(2);
    if (gs_l !== 3'd4 || sn_l !== 8'd5) begin
      errors++; $display("FAIL t3_lost_frozen: got status %0d step %0d want 4 5", gs_l, sn_l);
    end checks++;
    active = 1'b0; start_sw = 1'b0;
    tick();
    if (gs_l !== 3'd0 || sn_l !== 8'd0) begin
      errors++; $display("FAIL t3_leave_lost: got status %0d step %0d want 0 0", gs_l, sn_l);
    end checks++;
  endtask

  task automatic test_pause();
    do_reset();
    start_sw = 1'b1;
    tick();
    pause_sw = 1'b1;
    tick();
    if (gs_m !== 3'd5) begin errors++; $display("FAIL t4_pause_init: got %0d want 5", gs_m); end checks++;
    pause_sw = 1'b0;
    tick();
    if (gs_m !== 3'd1) begin errors++; $display("FAIL t4_resume_init: got %0d want 1", gs_m); end checks++;
    active = 1'b1;
    tick(2);
    pause_sw = 1'b1;
    tick();
    if (gs_m !== 3'd5 || sn_m !== 8'd2) begin
      errors++; $display("FAIL t4_pause_entry: got status %0d step %0d want 5 2", gs_m, sn_m);
    end checks++;
    win_flag = 1'b1;
    tick(4);
    if (gs_m !== 3'd5 || sn_m !== 8'd2) begin
      errors++; $display("FAIL t4_paused_ignore: got status %0d step %0d want 5 2", gs_m, sn_m);
    end checks++;
    win_flag = 1'b0; active = 1'b0; pause_sw = 1'b0;
    tick();
    if (gs_m !== 3'd2 || sn_m !== 8'd2) begin
      errors++; $display("FAIL t4_resume_gaming: got status %0d step %0d want 2 2", gs_m, sn_m);
    end checks++;
    pause_sw = 1'b1; win_flag = 1'b1;
    tick();
    if (gs_m !== 3'd3) begin errors++; $display("FAIL t4_win_over_pause: got %0d want 3", gs_m); end checks++;
    pause_sw = 1'b0; win_flag = 1'b0;
  endtask

  task automatic test_win_record();
    do_reset();
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(7);
    win_flag = 1'b1;
    tick();
    if (gs_m !== 3'd3 || sn_m !== 8'd7) begin
      errors++; $display("FAIL t5_win_drop_move: got status %0d step %0d want 3 7", gs_m, sn_m);
    end checks++;
    if (nr_m !== REC || bs_m !== (REC ? 8'd7 : 8'd0) || bv_m !== REC) begin
      errors++; $display("FAIL t5_first_record: got nr %0b best %0d valid %0b want %0b %0d %0b",
                         nr_m, bs_m, bv_m, REC, (REC ? 7 : 0), REC);
    end checks++;
    tick();
    if (nr_m !== 1'b0 || gs_m !== 3'd3 || sn_m !== 8'd7) begin
      errors++; $display("FAIL t5_pulse_end: got nr %0b status %0d step %0d want 0 3 7", nr_m, gs_m, sn_m);
    end checks++;
    active = 1'b0; win_flag = 1'b0; start_sw = 1'b0;
    tick();
    if (gs_m !== 3'd0 || sn_m !== 8'd0 || bs_m !== (REC ? 8'd7 : 8'd0) || bv_m !== REC) begin
      errors++; $display("FAIL t5_record_kept: got status %0d step %0d best %0d valid %0b", gs_m, sn_m, bs_m, bv_m);
    end checks++;
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(9);
    active = 1'b0; win_flag = 1'b1;
    tick();
    if (gs_m !== 3'd3 || sn_m !== 8'd9 || nr_m !== 1'b0 || bs_m !== (REC ? 8'd7 : 8'd0)) begin
      errors++; $display("FAIL t5_worse_win: got status %0d step %0d nr %0b best %0d", gs_m, sn_m, nr_m, bs_m);
    end checks++;
    win_flag = 1'b0; start_sw = 1'b0;
    tick();
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(4);
    active = 1'b0; win_flag = 1'b1;
    tick();
    if (sn_m !== 8'd4 || nr_m !== REC || bs_m !== (REC ? 8'd4 : 8'd0)) begin
      errors++; $display("FAIL t5_better_win: got step %0d nr %0b best %0d want 4 %0b %0d",
                         sn_m, nr_m, bs_m, REC, (REC ? 4 : 0));
    end checks++;
    tick();
    if (nr_m !== 1'b0) begin errors++; $display("FAIL t5_better_pulse_end: got %0b want 0", nr_m); end checks++;
    win_flag = 1'b0; start_sw = 1'b0;
    tick();
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(4);
    active = 1'b0; win_flag = 1'b1;
    tick();
    if (nr_m !== 1'b0 || bs_m !== (REC ? 8'd4 : 8'd0) || bv_m !== REC) begin
      errors++; $display("FAIL t5_equal_win: got nr %0b best %0d valid %0b", nr_m, bs_m, bv_m);
    end checks++;
    win_flag = 1'b0;
  endtask

  task automatic test_async_reset();
    start_sw = 1'b0;
    tick();
    start_sw = 1'b1;
    tick();
    active = 1'b1;
    tick(3);
    active = 1'b0;
    if (gs_m !== 3'd2 || sn_m !== 8'd3) begin
      errors++; $display("FAIL t6_pre_reset: got status %0d step %0d want 2 3", gs_m, sn_m);
    end checks++;
    #2;
    rst = 1'b1;
    #1;
    if (gs_m !== 3'd0 || sn_m !== 8'd0) begin
      errors++; $display("FAIL t6_async_state: got status %0d step %0d want 0 0", gs_m, sn_m);
    end checks++;
    if (bs_m !== 8'd0 || bv_m !== 1'b0 || nr_m !== 1'b0) begin
      errors++; $display("FAIL t6_async_record: got best %0d valid %0b nr %0b want 0 0 0", bs_m, bv_m, nr_m);
    end checks++;
    #1;
    rst = 1'b0;
    tick();
    if (gs_m !== 3'd1) begin errors++; $display("FAIL t6_restart: got %0d want 1", gs_m); end checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_limit();
    test_pause();
    test_win_record();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
